// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetcher and its queue.
package inst_fetcher_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } q_entry_t;

  // PC advance wraps naturally modulo 2^32
  function automatic logic [INST_W-1:0] next_pc(input logic [INST_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Memory fetch port plus decoder valid/ready port of the instruction fetcher.
interface inst_fetcher_if;
  import inst_fetcher_pkg::*;

  logic [INST_W-1:0] pc_to_mem;
  logic              en_to_mem;
  logic              drop_flag_to_mem;
  logic              ok_flag_from_mem;
  logic [INST_W-1:0] inst_from_mem;
  logic              inst_valid_out;
  logic [INST_W-1:0] inst_out;
  logic [INST_W-1:0] inst_pc_out;
  logic              inst_ready_in;

  modport master (
    output pc_to_mem, en_to_mem, drop_flag_to_mem,
    input  ok_flag_from_mem, inst_from_mem,
    output inst_valid_out, inst_out, inst_pc_out,
    input  inst_ready_in
  );

  modport slave (
    input  pc_to_mem, en_to_mem, drop_flag_to_mem,
    output ok_flag_from_mem, inst_from_mem,
    input  inst_valid_out, inst_out, inst_pc_out,
    output inst_ready_in
  );
endinterface

// File: rtl/inst_fetcher_queue.sv
// Show-ahead FIFO of {pc,inst} entries with registered head outputs and flush.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic     flush,
  input  logic     push,
  input  q_entry_t push_data,
  input  logic     pop,
  output logic     head_valid,
  output q_entry_t head_data,
  output logic     empty,
  output logic [AW:0] count
);

  localparam int CNT_W = AW + 1;

  q_entry_t          mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              head_valid_r;
  q_entry_t          head_data_r;

  logic              full_s, do_push_s, do_pop_s;
  logic [AW-1:0]     wr_next_s, rd_next_s;
  logic [CNT_W-1:0]  count_next_s;
  q_entry_t          head_next_s;

  // Next pointers/count and the head entry as it will look after this edge
  always_comb begin
    full_s       = (count_r == CNT_W'(DEPTH));
    do_push_s    = en & ~flush & push & (~full_s | pop);
    do_pop_s     = en & ~flush & pop & (count_r != CNT_W'(0));
    wr_next_s    = wr_ptr_r;
    rd_next_s    = rd_ptr_r;
    count_next_s = count_r;
    head_next_s  = '{pc: 32'h0, inst: 32'h0};
    if (flush) begin
      wr_next_s    = AW'(0);
      rd_next_s    = AW'(0);
      count_next_s = CNT_W'(0);
    end else begin
      if (do_push_s) wr_next_s = wr_ptr_r + AW'(1);
      else           wr_next_s = wr_ptr_r;
      if (do_pop_s)  rd_next_s = rd_ptr_r + AW'(1);
      else           rd_next_s = rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_next_s = count_r + CNT_W'(1);
        2'b01:   count_next_s = count_r - CNT_W'(1);
        default: count_next_s = count_r;
      endcase
    end
    // A push landing on the new head slot bypasses the storage array
    if (count_next_s == CNT_W'(0))                     head_next_s = '{pc: 32'h0, inst: 32'h0};
    else if (do_push_s && (wr_ptr_r == rd_next_s))     head_next_s = push_data;
    else                                               head_next_s = mem_r[rd_next_s];
  end

  // Storage array and pointer/count/head registers, all frozen while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '{pc: 32'h0, inst: 32'h0};
      wr_ptr_r     <= AW'(0);
      rd_ptr_r     <= AW'(0);
      count_r      <= CNT_W'(0);
      head_valid_r <= 1'b0;
      head_data_r  <= '{pc: 32'h0, inst: 32'h0};
    end else if (en) begin
      if (do_push_s) mem_r[wr_ptr_r] <= push_data;
      wr_ptr_r     <= wr_next_s;
      rd_ptr_r     <= rd_next_s;
      count_r      <= count_next_s;
      head_valid_r <= (count_next_s != CNT_W'(0));
      head_data_r  <= head_next_s;
    end
  end

  assign head_valid = head_valid_r;
  assign head_data  = head_data_r;
  assign empty      = (count_r == CNT_W'(0));
  assign count      = count_r;

endmodule

// File: rtl/inst_fetcher.sv
// Fetch FSM: walks the PC, issues one-word fetches, queues results, handles redirects.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 8,
  parameter int          QUEUE_AW    = 3,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  input  logic                redirect_in,
  input  logic [INST_W-1:0]   redirect_pc_in,
  inst_fetcher_if.master      bus
);

  localparam int CNT_W = QUEUE_AW + 1;

  fetch_state_e       state_r;
  logic [INST_W-1:0]  fetch_pc_r;
  logic [INST_W-1:0]  pc_to_mem_r;
  logic               en_r;
  logic               drop_r;

  logic               push_s, pop_s, flush_s;
  q_entry_t           push_data_s;
  logic               q_valid_s, q_empty_s;
  q_entry_t           q_head_s;
  logic [CNT_W-1:0]   q_count_s;

  // Queue control: a redirect cycle discards any push or pop
  always_comb begin
    flush_s     = rdy_in & redirect_in;
    push_s      = rdy_in & ~redirect_in & (state_r == ST_WAIT) & bus.ok_flag_from_mem;
    pop_s       = rdy_in & ~redirect_in & ~q_empty_s & bus.inst_ready_in;
    push_data_s = '{pc: fetch_pc_r, inst: bus.inst_from_mem};
  end

  inst_queue #(.DEPTH(QUEUE_DEPTH), .AW(QUEUE_AW)) u_queue (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .en         (rdy_in),
    .flush      (flush_s),
    .push       (push_s),
    .push_data  (push_data_s),
    .pop        (pop_s),
    .head_valid (q_valid_s),
    .head_data  (q_head_s),
    .empty      (q_empty_s),
    .count      (q_count_s)
  );

  // Fetch FSM with registered memory-side outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r     <= ST_IDLE;
      fetch_pc_r  <= RESET_PC;
      pc_to_mem_r <= 32'h0;
      en_r        <= 1'b0;
      drop_r      <= 1'b0;
    end else if (rdy_in) begin
      if (redirect_in) begin
        state_r    <= ST_DROP;
        fetch_pc_r <= redirect_pc_in;
        en_r       <= 1'b0;
        drop_r     <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            drop_r <= 1'b0;
            // A free slot is reserved for the single outstanding fetch
            if (q_count_s < CNT_W'(QUEUE_DEPTH)) begin
              en_r        <= 1'b1;
              pc_to_mem_r <= fetch_pc_r;
              state_r     <= ST_WAIT;
            end else begin
              en_r <= 1'b0;
            end
          end
          ST_WAIT: begin
            en_r   <= 1'b0;
            drop_r <= 1'b0;
            if (bus.ok_flag_from_mem) begin
              fetch_pc_r <= next_pc(fetch_pc_r);
              state_r    <= ST_IDLE;
            end
          end
          ST_DROP: begin
            en_r    <= 1'b0;
            drop_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: begin
            en_r    <= 1'b0;
            drop_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.pc_to_mem        = pc_to_mem_r;
  assign bus.en_to_mem        = en_r;
  assign bus.drop_flag_to_mem = drop_r;
  assign bus.inst_valid_out   = q_valid_s;
  assign bus.inst_out         = q_head_s.inst;
  assign bus.inst_pc_out      = q_head_s.pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: memory model, expectation tracker and head monitor.
module tb_inst_fetcher;
  import inst_fetcher_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, redirect_in;
  logic [31:0] redirect_pc_in;

  inst_fetcher_if bus();

  inst_fetcher #(.QUEUE_DEPTH(8), .QUEUE_AW(3), .RESET_PC(32'h0)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .bus            (bus)
  );

  always #5 clk_in = ~clk_in;

  int          tests = 0, fails = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_pc = 32'h0;
  bit          pend = 1'b0, rdy_seen = 1'b0, drop_exp = 1'b0;
  int          cnt = 0, en_count = 0, pops = 0;
  logic [31:0] pend_pc = 32'h0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], 16'hC0DE} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in); #3;
  endtask

  task automatic wait_en(input int budget);
    int n = 0;
    while (!bus.en_to_mem && n < budget) begin tick(); n++; end
    check("wait_en", {63'd0, bus.en_to_mem}, 64'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_in = 1'b1; redirect_pc_in = pc;
    tick();
    redirect_in = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_pc",    {32'd0, bus.pc_to_mem},   64'd0);
    check("rst_en",    {63'd0, bus.en_to_mem},   64'd0);
    check("rst_drop",  {63'd0, bus.drop_flag_to_mem}, 64'd0);
    check("rst_valid", {63'd0, bus.inst_valid_out}, 64'd0);
    check("rst_inst",  {32'd0, bus.inst_out},    64'd0);
    check("rst_ipc",   {32'd0, bus.inst_pc_out}, 64'd0);
  endtask

  // Memory model: answers each request 3 cycles later unless dropped
  initial begin
    bus.ok_flag_from_mem = 1'b0;
    bus.inst_from_mem    = 32'h0;
    forever begin
      @(posedge clk_in); #1;
      if (!rst_n_in) begin
        pend = 1'b0; bus.ok_flag_from_mem = 1'b0;
      end else if (rdy_seen) begin
        bus.ok_flag_from_mem = 1'b0;
        if (bus.drop_flag_to_mem) pend = 1'b0;
        else if (pend) begin
          cnt--;
          if (cnt == 0) begin
            bus.ok_flag_from_mem = 1'b1;
            bus.inst_from_mem    = inst_of(pend_pc);
            pend = 1'b0;
          end
        end
        if (bus.en_to_mem) begin
          check("one_outstanding", {63'd0, pend}, 64'd0);
          check("req_pc", {32'd0, bus.pc_to_mem}, {32'd0, exp_pc});
          en_count++;
          pend = 1'b1; cnt = 3; pend_pc = bus.pc_to_mem;
        end
      end
    end
  end

  // Expectation tracker: queues expected entries, tracks drop pulses and queue level
  initial forever begin
    @(negedge clk_in);
    if (!rst_n_in) begin
      sb.delete(); exp_pc = 32'h0; drop_exp = 1'b0; rdy_seen = 1'b0;
    end else begin
      rdy_seen = rdy_in;
      check("drop_flag", {63'd0, bus.drop_flag_to_mem}, {63'd0, drop_exp});
      check("valid_level", {63'd0, bus.inst_valid_out}, {63'd0, (sb.size() != 0)});
      if (rdy_in) begin
        if (redirect_in) begin
          sb.delete(); exp_pc = redirect_pc_in; drop_exp = 1'b1;
        end else begin
          drop_exp = 1'b0;
          if (bus.ok_flag_from_mem) begin
            sb.push_back({exp_pc, inst_of(exp_pc)});
            exp_pc = exp_pc + 32'd4;
          end
        end
      end
    end
  end

  // Monitor: compares every accepted head against the scoreboard
  initial forever begin
    logic [63:0] e;
    @(negedge clk_in); #1;
    if (rst_n_in && rdy_in && !redirect_in && bus.inst_valid_out && bus.inst_ready_in) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_head: got %h_%h, expected no entry", bus.inst_pc_out, bus.inst_out);
      end else begin
        e = sb.pop_front();
        check("head", {bus.inst_pc_out, bus.inst_out}, e);
        pops++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n_in = 1'b0; rdy_in = 1'b1; redirect_in = 1'b0; redirect_pc_in = 32'h0;
    bus.inst_ready_in = 1'b1;
    #1 check_reset_outputs();
    repeat (3) tick();
    rst_n_in = 1'b1;

    // Reset in the middle of the third fetch (PC 8)
    repeat (3) begin wait_en(20); tick(); end
    rst_n_in = 1'b0;
    #1 check_reset_outputs();
    repeat (2) tick();
    rst_n_in = 1'b1;

    // Streaming with decoder always ready
    base = pops;
    repeat (40) tick();
    check("stream_progress", {63'd0, (pops - base >= 6)}, 64'd1);

    // Backpressure: restart at 0x40 with decoder stalled
    bus.inst_ready_in = 1'b0;
    pulse_redirect(32'h0000_0040);
    base = en_count;
    repeat (60) tick();
    check("bp_requests", 64'(en_count - base), 64'd8);
    check("bp_fill", 64'(sb.size()), 64'd8);
    check("bp_en_idle", {63'd0, bus.en_to_mem}, 64'd0);
    bus.inst_ready_in = 1'b1;
    tick();
    bus.inst_ready_in = 1'b0;
    repeat (20) tick();
    check("bp_one_more", 64'(en_count - base), 64'd9);
    bus.inst_ready_in = 1'b1;
    repeat (20) tick();

    // Redirect landing on the same cycle as ok
    begin
      int n = 0;
      while (!bus.ok_flag_from_mem && n < 20) begin tick(); n++; end
      check("wait_ok", {63'd0, bus.ok_flag_from_mem}, 64'd1);
    end
    pulse_redirect(32'h0000_1000);
    repeat (20) tick();

    // Back-to-back redirects: two drop cycles, restart at 0x300
    redirect_in = 1'b1; redirect_pc_in = 32'h0000_0200;
    tick();
    redirect_pc_in = 32'h0000_0300;
    tick();
    redirect_in = 1'b0;
    check("b2b_drop", {63'd0, bus.drop_flag_to_mem}, 64'd1);
    repeat (20) tick();

    // Global freeze for 5 cycles while a fetch is outstanding
    wait_en(20);
    tick();
    rdy_in = 1'b0;
    repeat (5) begin
      tick();
      check("frz_en", {63'd0, bus.en_to_mem}, 64'd0);
      check("frz_pc", {32'd0, bus.pc_to_mem}, {32'd0, exp_pc});
      check("frz_drop", {63'd0, bus.drop_flag_to_mem}, 64'd0);
    end
    rdy_in = 1'b1;
    base = pops;
    repeat (30) tick();
    check("frz_resume", {63'd0, (pops - base >= 4)}, 64'd1);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 10) begin tick(); n++; end
      check("drain", 64'(sb.size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
